// File: rtl/bp_pkg.sv
// Types and helpers shared by the fetch-side predictor and the EX-side resolver.
// Keeping the index hash here means both ends always agree on which BHT entry a PC selects.
package bp_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Word-aligned index: pc[idx_w+1:2]. Bits above alias deliberately, pc[1:0] is ignored.
  function automatic logic [31:0] bht_index(input logic [31:0] pc, input int unsigned idx_w);
    logic [31:0] mask;
    mask = (32'd1 << idx_w) - 32'd1;
    return (pc >> 2) & mask;
  endfunction

endpackage

// File: rtl/bp_sat2.sv
// 2-bit saturating counter next-state: count up on taken, down on not-taken, clamp at ST/SNT.
module bp_sat2
  import bp_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       taken,
  output logic [1:0] nxt
);

  always_comb begin
    nxt = cur;
    if (taken) begin
      if (cur != ST) nxt = cur + 2'd1;
    end else begin
      if (cur != SNT) nxt = cur - 2'd1;
    end
  end

endmodule

// File: rtl/bht_resolve.sv
// EX-side branch resolver: owns the BHT, detects mispredictions, issues a registered
// flush/redirect, suppresses wrong-path branches for a few cycles, and keeps statistics.
module bht_resolve
  import bp_pkg::*;
#(
  parameter int IDX_W  = 6,
  parameter int SHADOW = 2,
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic              ex_is_branch,
  input  logic [31:0]       ex_pc,
  input  logic              ex_pred_taken,
  input  logic [31:0]       ex_pred_target,
  input  logic              ex_taken,
  input  logic [31:0]       ex_target,
  input  logic [31:0]       lk_pc,
  output logic              lk_taken,
  output logic              flush,
  output logic [31:0]       redirect_pc,
  output logic [STAT_W-1:0] br_count,
  output logic [STAT_W-1:0] mp_count
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int SH_W  = 3;

  logic [1:0]        bht_q [DEPTH];
  logic [1:0]        bht_d [DEPTH];
  logic [SH_W-1:0]   shadow_q, shadow_d;
  logic              flush_q, flush_d;
  logic [31:0]       redirect_q, redirect_d;
  logic [STAT_W-1:0] br_q, br_d;
  logic [STAT_W-1:0] mp_q, mp_d;

  logic [IDX_W-1:0] ex_idx, lk_idx;
  logic [1:0]       cur_ctr, nxt_ctr;
  logic             acc, mis;

  assign ex_idx  = IDX_W'(bht_index(ex_pc, IDX_W));
  assign lk_idx  = IDX_W'(bht_index(lk_pc, IDX_W));
  assign cur_ctr = bht_q[ex_idx];

  // Lookup reads the registered table, so a same-cycle update is not visible here.
  assign lk_taken = bht_q[lk_idx][1];

  assign acc = ex_valid & ex_is_branch & (shadow_q == '0);
  assign mis = acc & ((ex_pred_taken != ex_taken) |
                      (ex_taken & ex_pred_taken & (ex_pred_target != ex_target)));

  bp_sat2 u_sat2 (
    .cur   (cur_ctr),
    .taken (ex_taken),
    .nxt   (nxt_ctr)
  );

  always_comb begin
    bht_d = bht_q;
    if (acc) bht_d[ex_idx] = nxt_ctr;

    flush_d    = mis;
    redirect_d = redirect_q;
    if (mis) redirect_d = ex_taken ? ex_target : ex_pc + 32'd4;

    shadow_d = shadow_q;
    if (mis)                   shadow_d = SH_W'(SHADOW);
    else if (shadow_q != '0)   shadow_d = shadow_q - 1'b1;

    br_d = br_q;
    if (acc && (br_q != '1)) br_d = br_q + 1'b1;
    mp_d = mp_q;
    if (mis && (mp_q != '1)) mp_d = mp_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) bht_q[i] <= WNT;
      shadow_q   <= '0;
      flush_q    <= 1'b0;
      redirect_q <= '0;
      br_q       <= '0;
      mp_q       <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) bht_q[i] <= bht_d[i];
      shadow_q   <= shadow_d;
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
      br_q       <= br_d;
      mp_q       <= mp_d;
    end
  end

  assign flush       = flush_q;
  assign redirect_pc = redirect_q;
  assign br_count    = br_q;
  assign mp_count    = mp_q;

endmodule

// File: tb/tb_bht_resolve.sv
// Scoreboard bench for bht_resolve: the driver queues the expected post-edge state for
// every slot it issues, and an independent monitor pops and compares one entry per cycle.
module tb_bht_resolve;
  import bp_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 1'b0, ex_is_branch = 1'b0;
  logic [31:0] ex_pc = '0;
  logic        ex_pred_taken = 1'b0;
  logic [31:0] ex_pred_target = '0;
  logic        ex_taken = 1'b0;
  logic [31:0] ex_target = '0;
  logic [31:0] lk_pc = '0;
  logic        lk_taken, flush;
  logic [31:0] redirect_pc, br_count, mp_count;

  bht_resolve #(.IDX_W(6), .SHADOW(2), .STAT_W(32)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .ex_taken(ex_taken), .ex_target(ex_target),
    .lk_pc(lk_pc), .lk_taken(lk_taken),
    .flush(flush), .redirect_pc(redirect_pc),
    .br_count(br_count), .mp_count(mp_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic [31:0] redir;
    logic [31:0] br;
    logic [31:0] mp;
    logic        lk;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input string field, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s.%s got %0h want %0h", nm, field, got, want);
    end
  endtask

  // Monitor: registered outputs settle just after the edge the driver waited on.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.name, "flush",    {31'd0, flush},    {31'd0, e.flush});
        chk(e.name, "redirect", redirect_pc,       e.redir);
        chk(e.name, "br_count", br_count,          e.br);
        chk(e.name, "mp_count", mp_count,          e.mp);
        chk(e.name, "lk_taken", {31'd0, lk_taken}, {31'd0, e.lk});
        $display("txn %-12s flush=%0d redir=%08h br=%0d mp=%0d lk=%0d",
                 e.name, flush, redirect_pc, br_count, mp_count, lk_taken);
      end
    end
  end

  task automatic tx(input logic rst, input logic v, input logic b, input logic [31:0] pc,
                    input logic pt, input logic [31:0] ptg, input logic tk, input logic [31:0] tg,
                    input logic [31:0] lk, input logic ef, input logic [31:0] er,
                    input logic [31:0] eb, input logic [31:0] em, input logic el, input string nm);
    exp_t e;
    @(negedge clk);
    reset = rst; ex_valid = v; ex_is_branch = b; ex_pc = pc;
    ex_pred_taken = pt; ex_pred_target = ptg; ex_taken = tk; ex_target = tg; lk_pc = lk;
    @(posedge clk);
    e.flush = ef; e.redir = er; e.br = eb; e.mp = em; e.lk = el; e.name = nm;
    q.push_back(e);
  endtask

  task automatic idle(input logic [31:0] lk, input logic [31:0] er, input logic [31:0] eb,
                      input logic [31:0] em, input logic el, input string nm);
    tx(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, lk, 1'b0, er, eb, em, el, nm);
  endtask

  initial begin
    int waited;
    // 1: reset state
    tx(1, 0, 0, 32'h0,   0, 32'h0, 0, 32'h0, 32'h100, 0, 32'h0, 0, 0, 0, "reset");
    idle(32'h100, 32'h0, 0, 0, 0, "post_reset");
    // 2: not-taken predicted, taken resolved
    tx(0, 1, 1, 32'h100, 0, 32'h0, 1, 32'h200, 32'h100, 1, 32'h200, 1, 1, 1, "mis_nt_t");
    idle(32'h100, 32'h200, 1, 1, 1, "shadow_a1");
    idle(32'h100, 32'h200, 1, 1, 1, "shadow_a2");
    // 3: correct not-taken saturates at SNT; a taken then only reaches WNT
    tx(0, 1, 1, 32'h104, 0, 32'h0, 0, 32'h0,   32'h104, 0, 32'h200, 2, 1, 0, "nt_ok1");
    tx(0, 1, 1, 32'h104, 0, 32'h0, 0, 32'h0,   32'h104, 0, 32'h200, 3, 1, 0, "nt_ok2");
    tx(0, 1, 1, 32'h104, 0, 32'h0, 1, 32'h108, 32'h104, 1, 32'h108, 4, 2, 0, "sat_probe");
    idle(32'h104, 32'h108, 4, 2, 0, "shadow_b1");
    idle(32'h104, 32'h108, 4, 2, 0, "shadow_b2");
    // 4: mispredict, two shadowed branches dropped, third accepted
    tx(0, 1, 1, 32'h208, 1, 32'h300, 0, 32'h0,   32'h208, 1, 32'h20C, 5, 3, 0, "mis_t_nt");
    tx(0, 1, 1, 32'h20C, 0, 32'h0,   1, 32'h400, 32'h20C, 0, 32'h20C, 5, 3, 0, "drop_t1");
    tx(0, 1, 1, 32'h20C, 0, 32'h0,   1, 32'h400, 32'h20C, 0, 32'h20C, 5, 3, 0, "drop_t2");
    tx(0, 1, 1, 32'h20C, 0, 32'h0,   1, 32'h400, 32'h20C, 1, 32'h400, 6, 4, 1, "accept_t3");
    idle(32'h20C, 32'h400, 6, 4, 1, "shadow_c1");
    idle(32'h20C, 32'h400, 6, 4, 1, "shadow_c2");
    tx(0, 1, 0, 32'h20C, 0, 32'h0,   1, 32'h999, 32'h20C, 0, 32'h400, 6, 4, 1, "non_branch");
    // 5: target mismatch, then taken-predicted resolved not-taken, then a correct taken
    tx(0, 1, 1, 32'h300, 1, 32'h400, 1, 32'h500, 32'h300, 1, 32'h500, 7, 5, 1, "tgt_mis");
    idle(32'h300, 32'h500, 7, 5, 1, "shadow_d1");
    idle(32'h300, 32'h500, 7, 5, 1, "shadow_d2");
    tx(0, 1, 1, 32'h300, 1, 32'h400, 0, 32'h0,   32'h300, 1, 32'h304, 8, 6, 1, "mis_pc4");
    idle(32'h300, 32'h304, 8, 6, 1, "shadow_e1");
    idle(32'h300, 32'h304, 8, 6, 1, "shadow_e2");
    tx(0, 1, 1, 32'h300, 1, 32'h600, 1, 32'h600, 32'h300, 0, 32'h304, 9, 6, 1, "t_ok");
    // 6: aliased PCs accumulate on one entry: 01->10->11, then 11->10 keeps taken
    tx(0, 1, 1, 32'h110,  1, 32'h800, 1, 32'h800, 32'h1110, 0, 32'h304, 10, 6, 1, "alias1");
    tx(0, 1, 1, 32'h1110, 1, 32'h800, 1, 32'h800, 32'h110,  0, 32'h304, 11, 6, 1, "alias2");
    tx(0, 1, 1, 32'h110,  0, 32'h0,   0, 32'h0,   32'h1110, 0, 32'h304, 12, 6, 1, "alias_nt");
    // Reset wins over a mispredict on the same edge
    tx(1, 1, 1, 32'h110,  1, 32'h0,   0, 32'h0,   32'h300,  0, 32'h0,   0,  0, 0, "rst_on_mis");
    tx(0, 1, 1, 32'h300,  1, 32'h900, 1, 32'h900, 32'h300,  0, 32'h0,   1,  0, 1, "post_rst_t");
    tx(0, 1, 1, 32'h300,  0, 32'h0,   0, 32'h0,   32'h300,  0, 32'h0,   2,  0, 0, "post_rst_nt");
    tx(0, 0, 0, 32'h0,    0, 32'h0,   0, 32'h0,   32'h110,  0, 32'h0,   2,  0, 0, "post_rst_lk");

    waited = 0;
    while (q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #2;
    if (q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain pending %0d want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bht_resolve.md
Name: bht_resolve

Overview:
- Execute-end counterpart of the fetch-side branch predictor.
- Takes resolved conditional branches (opcode 1100011) from EX, owns the 2-bit saturating branch history table (BHT), and flags mispredictions with a registered flush/redirect.
- Serves the fetch-side lookup port.
- Counts branches and mispredictions for the performance registers.

Parameters:
- IDX_W, 6: BHT index width. Table depth is 2**IDX_W; index = pc[IDX_W+1:2].
- SHADOW, 2: cycles after a flush during which EX inputs are ignored as wrong-path. Legal range 1..7.
- STAT_W, 32: width of the saturating statistics counters.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ex_valid  in  1  EX slot holds a real instruction this cycle
- ex_is_branch  in  1  EX instruction is a conditional branch (fetch-side tag carried down the pipe)
- ex_pc  in  32  PC of the EX instruction
- ex_pred_taken  in  1  direction predicted at fetch
- ex_pred_target  in  32  target predicted at fetch; don't-care if not predicted taken
- ex_taken  in  1  resolved direction
- ex_target  in  32  resolved taken target
- lk_pc  in  32  fetch PC for lookup
- lk_taken  out  1  prediction for lk_pc; combinational = bht[lk_pc[IDX_W+1:2]][1]
- flush  out  1  registered mispredict pulse
- redirect_pc  out  32  registered correct next PC, valid when flush=1
- br_count  out  STAT_W  resolved branches accepted
- mp_count  out  STAT_W  mispredictions detected

Behaviour:
Reset (synchronous, highest priority over every other event):
- All BHT entries = 2'b01 (weakly not-taken).
- flush=0, redirect_pc=0, br_count=0, mp_count=0, shadow counter=0.

Accept:
- acc = ex_valid & ex_is_branch & (shadow==0).
- Non-branches and shadowed slots cause no state change.

Mispredict:
- mis = acc & ((ex_pred_taken != ex_taken) | (ex_taken & ex_pred_taken & (ex_pred_target != ex_target))).

Latency: one cycle. On the edge after the accept cycle:
- flush <= mis.
- redirect_pc <= ex_taken ? ex_target : ex_pc+32'd4 when mis; otherwise holds its value.
- flush is a one-cycle pulse.

Shadow:
- When mis is registered, shadow <= SHADOW.
- Otherwise it decrements while nonzero.
- A branch arriving while shadow!=0 is dropped: no BHT write, no count, no flush.

BHT update on accept, same edge as flush, idx = ex_pc[IDX_W+1:2]:
- taken: 00->01->10->11, saturates at 11.
- not-taken: 11->10->01->00, saturates at 00.
- The update is read-modify-write of the current array contents, so back-to-back branches to one index accumulate (two taken from 01 -> 11).

Counters:
- br_count += acc.
- mp_count += mis.
- Both saturate at all-ones and never wrap.

Lookup:
- Purely combinational.
- A same-cycle update to the looked-up index is not forwarded; lookup returns the pre-edge value.

Index aliasing:
- PCs differing only above bit IDX_W+1 share an entry by design.
- ex_pc[1:0] is ignored.

Reset asserted mid-shadow or on a flush edge: reset wins; flush=0 next cycle.

Decomposition:
- Shared package (bp_pkg):
  - OPC_BRANCH = 7'b1100011.
  - Counter state constants SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - The index-extraction function, shared with the fetch-side predictor so the hashing stays identical on both ends.
- One sub-module, bp_sat2: pure 2-bit saturating next-state function (cur, taken -> next).
- Table, shadow counter, flush register and statistics stay in bht_resolve.

Test Plan:
1. Reset, then lk_pc=0x100 -> lk_taken=0; br_count=0, mp_count=0, flush=0.
2. Branch pc=0x100, pred_taken=0, taken=1, target=0x200 -> next cycle flush=1, redirect_pc=0x200, mp_count=1, bht[0]=10, lk_taken(0x100)=1.
3. Correct not-taken at pc=0x104 (pred 0, taken 0) -> flush stays 0, br_count+1, bht[1] 01->00; repeat -> stays 00.
4. Mispredict at cycle t, then valid branches at t+1 and t+2 (SHADOW=2) -> both ignored: counts unchanged, no flush. A branch at t+3 is accepted.
5. Target mismatch, pc=0x300: pred_taken=1, pred_target=0x400, taken=1, target=0x500 -> flush=1, redirect_pc=0x500. Taken predicted not-taken at pc=0x300 -> redirect_pc=0x304 only if the pc+4 path is correct; check that not-taken mispredict at 0x300 gives 0x304.
6. Two consecutive taken branches, pc=0x100 then 0x1100 (alias, IDX_W=6) -> entry 01->10->11; reset asserted with flush pending -> flush=0 and all entries 01 next cycle.
